i2c_read_nbyte: RTL and testbench
=================================

Name: i2c_read_nbyte

Overview:
- Parametrised I2C master for sensor readout. Reads 1..MAX_BYTES data bytes from a 7-bit slave.
- Optionally writes a register pointer first, then issues a repeated START before the read.
- Adds over the fixed 2-byte reader: programmable SCL timing, per-byte streaming strobe, sticky NACK error reporting, START on a GO rising edge.
- Sits between the sensor-control FSM and the open-drain pad logic; SDAO=0 drives low, SDAO=1 releases.

Parameters:
- MAX_BYTES, 4: maximum bytes per transaction; DATA_OUT width = 8*MAX_BYTES.
- CLK_DIV, 4: CLK cycles per SCL quarter-period, ≥1; SCL period = 4*CLK_DIV CLK cycles.

Ports:
- CLK  in  1: system clock.
- RESET_N  in  1: reset, asynchronous, active-low.
- GO  in  1: transaction request; a rising edge while idle starts a transaction.
- SLAVE_ADDR  in  7: 7-bit slave address, captured at start.
- REG_EN  in  1: 1 = write REG_ADDR before reading; captured at start.
- REG_ADDR  in  8: register pointer, captured at start.
- NUM_BYTES  in  8: bytes to read; 0 is treated as 1; values > MAX_BYTES are clamped to MAX_BYTES.
- SDAI  in  1: SDA pad input.
- SDAO  out  1: SDA drive (0 = pull low).
- SCLO  out  1: SCL drive.
- BUSY  out  1: high from start until DONE.
- DONE  out  1: one-cycle pulse at end of transaction.
- ACK_ERR  out  1: slave NACKed an address/register byte; valid at DONE, held until next start.
- BYTE_VALID  out  1: one-cycle pulse per received byte.
- BYTE_DATA  out  8: the received byte, valid with BYTE_VALID.
- DATA_OUT  out  8*MAX_BYTES: accumulated data; the last byte is in [7:0], earlier bytes shift upward, unused upper bytes are 0.

Behaviour:
- Reset (async, any state): SDAO=1, SCLO=1, BUSY=0, DONE=0, ACK_ERR=0, BYTE_VALID=0, BYTE_DATA=0, DATA_OUT=0, state IDLE. The bus is released in the same cycle.
- GO handling: GO is registered. Start condition is GO=1 and previous GO=0 while in IDLE. A held GO does not retrigger. GO edges while BUSY are ignored.
- At start: capture the inputs, clear DATA_OUT and ACK_ERR, set BUSY=1.
- Timing uses a quarter tick every CLK_DIV cycles. Each bit uses quarters Q0..Q3:
  - Q0: SCL=0, drive SDA.
  - Q1: SCL=1.
  - Q2: SCL=1, sample SDAI.
  - Q3: SCL=0.
- START: SDA 1→0 while SCL=1, then SCL→0.
- STOP: SDA=0 with SCL=0, SCL→1, then SDA→1.
- Repeated START: SDA=1, SCL=1, then the START sequence.
- State sequence:
  - IDLE
  - START
  - if REG_EN: ADDR_W ({addr,0}, 8 bits + ACK) → REG (REG_ADDR + ACK) → RSTART
  - ADDR_R ({addr,1} + ACK)
  - READ (8 bits, MSB first)
  - MACK
  - loop READ/MACK until the count is reached
  - STOP → FIN → IDLE
- ACK slot (address/register): SDAO=1, sample at Q2. SDAI=1 means NACK: set ACK_ERR=1, skip to STOP. No read bytes are produced and DATA_OUT stays 0.
- MACK: master drives SDAO=0 (ACK) after bytes 1..N-1, and SDAO=1 (NACK) after byte N.
- Byte receive: on the 8th bit sample, BYTE_DATA ← byte, BYTE_VALID pulses for 1 cycle, and DATA_OUT ← {DATA_OUT[8*MAX_BYTES-9:0], byte}.
- FIN: DONE=1 for one cycle, BUSY→0 in the same cycle; the bus is idle (1,1).
- Clock stretching is not supported: SCL is driven open-loop.

Test Plan:
- No-register read: REG_EN=0, SLAVE_ADDR=0x40, NUM_BYTES=2, MAX_BYTES=4, slave model ACKs and returns 0xAB, 0xCD.
  - Address byte seen is 0x81.
  - Master ACK after 0xAB, NACK after 0xCD.
  - Two BYTE_VALID pulses with BYTE_DATA 0xAB then 0xCD.
  - DATA_OUT=0x0000ABCD, DONE pulse, ACK_ERR=0.
- Register read: REG_EN=1, addr 0x1E, REG_ADDR=0x03, NUM_BYTES=4, returns 0x11, 0x22, 0x33, 0x44.
  - Bus shows 0x3C, 0x03, repeated START, 0x3D.
  - DATA_OUT=0x11223344.
- Address NACK: the slave never ACKs. ACK_ERR=1 at DONE, zero BYTE_VALID pulses, a STOP is issued, DATA_OUT=0.
- Boundaries:
  - NUM_BYTES=0 → exactly 1 byte read, followed by NACK.
  - NUM_BYTES=9 with MAX_BYTES=4 → 4 bytes read.
  - GO held high after DONE → no second transaction.
- Timing and reset: CLK_DIV=4 gives SCL period = 16 CLK cycles. Asserting RESET_N=0 in the middle of a read byte drives SDAO=1 and SCLO=1 immediately, and all outputs take their reset values.

Source files
------------

// File: rtl/i2c_read_nbyte.sv
// I2C master: reads 1..MAX_BYTES bytes from a 7-bit slave,
// optionally writing a register pointer and repeated START first.
module i2c_read_nbyte #(
   parameter int MAX_BYTES = 4,
   parameter int CLK_DIV   = 4
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   GO,
   input  logic [6:0]             SLAVE_ADDR,
   input  logic                   REG_EN,
   input  logic [7:0]             REG_ADDR,
   input  logic [7:0]             NUM_BYTES,
   input  logic                   SDAI,
   output logic                   SDAO,
   output logic                   SCLO,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   ACK_ERR,
   output logic                   BYTE_VALID,
   output logic [7:0]             BYTE_DATA,
   output logic [8*MAX_BYTES-1:0] DATA_OUT
);

   localparam int DW = 8 * MAX_BYTES;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR_W,
      S_REG,
      S_RSTART,
      S_ADDR_R,
      S_READ,
      S_MACK,
      S_STOP,
      S_FIN
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] div_cnt, div_cnt_n;
   logic [1:0]    qtr, qtr_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    byte_cnt, byte_cnt_n;
   logic [7:0]    last_idx, last_idx_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic [6:0]    addr_q, addr_n;
   logic          reg_en_q, reg_en_n;
   logic [7:0]    reg_q, reg_n;
   logic          go_q;
   logic          busy_n, done_n, ack_err_n, bv_n;
   logic [7:0]    bd_n;
   logic [DW-1:0] data_n;
   logic          sda_c, scl_c, scl_hi;
   logic          tick, start, is_addr;
   logic [7:0]    num_clamp, rx_byte;

   assign tick    = (div_cnt == CW'(CLK_DIV - 1));
   assign start   = GO & ~go_q;
   assign rx_byte = {rx_sh[6:0], SDAI};
   assign scl_hi  = qtr[0] ^ qtr[1];
   assign is_addr = (state == S_ADDR_W) || (state == S_REG) ||
                    (state == S_ADDR_R);

   // Byte count: 0 reads one byte, oversize requests clamp to MAX_BYTES
   always_comb begin
      num_clamp = NUM_BYTES;
      if (NUM_BYTES == 8'd0)
         num_clamp = 8'd1;
      else if (NUM_BYTES > 8'(MAX_BYTES))
         num_clamp = 8'(MAX_BYTES);
   end

   // Next-state and datapath updates, stepped on quarter ticks
   always_comb begin
      state_n    = state;
      div_cnt_n  = div_cnt;
      qtr_n      = qtr;
      bit_cnt_n  = bit_cnt;
      byte_cnt_n = byte_cnt;
      last_idx_n = last_idx;
      tx_sh_n    = tx_sh;
      rx_sh_n    = rx_sh;
      addr_n     = addr_q;
      reg_en_n   = reg_en_q;
      reg_n      = reg_q;
      busy_n     = BUSY;
      done_n     = 1'b0;
      ack_err_n  = ACK_ERR;
      bv_n       = 1'b0;
      bd_n       = BYTE_DATA;
      data_n     = DATA_OUT;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n    = S_START;
               addr_n     = SLAVE_ADDR;
               reg_en_n   = REG_EN;
               reg_n      = REG_ADDR;
               last_idx_n = num_clamp - 8'd1;
               busy_n     = 1'b1;
               ack_err_n  = 1'b0;
               data_n     = '0;
               div_cnt_n  = '0;
               qtr_n      = 2'd0;
               bit_cnt_n  = 4'd0;
               byte_cnt_n = 8'd0;
            end
         end
         S_FIN: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: begin
            div_cnt_n = tick ? '0 : div_cnt + CW'(1);
            if (tick) begin
               qtr_n = qtr + 2'd1;
               if (qtr == 2'd2) begin
                  if (state == S_READ) begin
                     rx_sh_n = rx_byte;
                     if (bit_cnt == 4'd7) begin
                        bv_n   = 1'b1;
                        bd_n   = rx_byte;
                        data_n = (DATA_OUT << 8) | DW'(rx_byte);
                     end
                  end else if (is_addr && bit_cnt == 4'd8 && SDAI) begin
                     ack_err_n = 1'b1;
                  end
               end
               if (qtr == 2'd3) begin
                  case (state)
                     S_START: begin
                        bit_cnt_n = 4'd0;
                        if (reg_en_q) begin
                           state_n = S_ADDR_W;
                           tx_sh_n = {addr_q, 1'b0};
                        end else begin
                           state_n = S_ADDR_R;
                           tx_sh_n = {addr_q, 1'b1};
                        end
                     end
                     S_ADDR_W, S_REG, S_ADDR_R: begin
                        if (bit_cnt != 4'd8) begin
                           bit_cnt_n = bit_cnt + 4'd1;
                           tx_sh_n   = {tx_sh[6:0], 1'b0};
                        end else begin
                           bit_cnt_n = 4'd0;
                           if (ACK_ERR)
                              state_n = S_STOP;
                           else if (state == S_ADDR_W) begin
                              state_n = S_REG;
                              tx_sh_n = reg_q;
                           end else if (state == S_REG)
                              state_n = S_RSTART;
                           else
                              state_n = S_READ;
                        end
                     end
                     S_RSTART: begin
                        state_n   = S_ADDR_R;
                        bit_cnt_n = 4'd0;
                        tx_sh_n   = {addr_q, 1'b1};
                     end
                     S_READ: begin
                        if (bit_cnt == 4'd7) begin
                           state_n   = S_MACK;
                           bit_cnt_n = 4'd0;
                        end else begin
                           bit_cnt_n = bit_cnt + 4'd1;
                        end
                     end
                     S_MACK: begin
                        if (byte_cnt == last_idx) begin
                           state_n = S_STOP;
                        end else begin
                           state_n    = S_READ;
                           byte_cnt_n = byte_cnt + 8'd1;
                        end
                     end
                     S_STOP: state_n = S_FIN;
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   // Bus levels for the current state and quarter
   always_comb begin
      sda_c = 1'b1;
      scl_c = 1'b1;
      unique case (state)
         S_START: begin
            sda_c = ~qtr[1];
            scl_c = (qtr != 2'd3);
         end
         S_RSTART: begin
            sda_c = ~qtr[1];
            scl_c = scl_hi;
         end
         S_ADDR_W, S_REG, S_ADDR_R: begin
            sda_c = (bit_cnt == 4'd8) ? 1'b1 : tx_sh[7];
            scl_c = scl_hi;
         end
         S_READ: begin
            sda_c = 1'b1;
            scl_c = scl_hi;
         end
         S_MACK: begin
            sda_c = (byte_cnt == last_idx);
            scl_c = scl_hi;
         end
         S_STOP: begin
            sda_c = (qtr == 2'd3);
            scl_c = (qtr != 2'd0);
         end
         default: ;
      endcase
   end

   // State and output registers; reset releases the bus at once
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         qtr        <= 2'd0;
         bit_cnt    <= 4'd0;
         byte_cnt   <= 8'd0;
         last_idx   <= 8'd0;
         tx_sh      <= 8'd0;
         rx_sh      <= 8'd0;
         addr_q     <= 7'd0;
         reg_en_q   <= 1'b0;
         reg_q      <= 8'd0;
         go_q       <= 1'b0;
         SDAO       <= 1'b1;
         SCLO       <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ACK_ERR    <= 1'b0;
         BYTE_VALID <= 1'b0;
         BYTE_DATA  <= 8'd0;
         DATA_OUT   <= '0;
      end else begin
         state      <= state_n;
         div_cnt    <= div_cnt_n;
         qtr        <= qtr_n;
         bit_cnt    <= bit_cnt_n;
         byte_cnt   <= byte_cnt_n;
         last_idx   <= last_idx_n;
         tx_sh      <= tx_sh_n;
         rx_sh      <= rx_sh_n;
         addr_q     <= addr_n;
         reg_en_q   <= reg_en_n;
         reg_q      <= reg_n;
         go_q       <= GO;
         SDAO       <= sda_c;
         SCLO       <= scl_c;
         BUSY       <= busy_n;
         DONE       <= done_n;
         ACK_ERR    <= ack_err_n;
         BYTE_VALID <= bv_n;
         BYTE_DATA  <= bd_n;
         DATA_OUT   <= data_n;
      end
   end

endmodule

// File: tb/tb_i2c_read_nbyte.sv
// Bench for i2c_read_nbyte: behavioural slave on the open-drain
// bus, directed transactions with hand-computed expectations.
module tb_i2c_read_nbyte;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        GO = 1'b0;
   logic [6:0]  SLAVE_ADDR = 7'd0;
   logic        REG_EN = 1'b0;
   logic [7:0]  REG_ADDR = 8'd0;
   logic [7:0]  NUM_BYTES = 8'd0;
   logic        SDAO, SCLO, BUSY, DONE, ACK_ERR, BYTE_VALID;
   logic [7:0]  BYTE_DATA;
   logic [31:0] DATA_OUT;

   logic s_sda = 1'b1;
   wire  sda_line = SDAO & s_sda;

   i2c_read_nbyte #(.MAX_BYTES(4), .CLK_DIV(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .GO(GO),
      .SLAVE_ADDR(SLAVE_ADDR), .REG_EN(REG_EN),
      .REG_ADDR(REG_ADDR), .NUM_BYTES(NUM_BYTES),
      .SDAI(sda_line), .SDAO(SDAO), .SCLO(SCLO),
      .BUSY(BUSY), .DONE(DONE), .ACK_ERR(ACK_ERR),
      .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
      .DATA_OUT(DATA_OUT)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave model state
   logic [7:0] tx_data [8];
   logic       ack_en = 1'b1;
   logic       slv_kick = 1'b0;
   logic       kick_p = 1'b0;
   logic       scl_p = 1'b1, sda_p = 1'b1;
   int         bitc = 0, tx_idx = 0, starts = 0, stops = 0;
   logic       rd_mode = 1'b0, in_addr = 1'b0, last_mack = 1'b1;
   logic [7:0] sh = 8'd0, cur;
   logic [7:0] wr_log [$];
   logic [7:0] mack_log [$];
   logic [7:0] byte_log [$];
   int         rise_log [$];
   int         done_cnt = 0;

   always @(SCLO or sda_line or slv_kick) begin
      if (slv_kick !== kick_p) begin
         kick_p  = slv_kick;
         bitc    = 0;
         rd_mode = 1'b0;
         in_addr = 1'b0;
         s_sda   = 1'b1;
      end else if (SCLO === 1'b1 && scl_p === 1'b1) begin
         if (sda_p === 1'b1 && sda_line === 1'b0) begin
            starts++;
            bitc = 0; in_addr = 1'b1; rd_mode = 1'b0; tx_idx = 0;
         end else if (sda_p === 1'b0 && sda_line === 1'b1) begin
            stops++;
            bitc = 0; in_addr = 1'b0; rd_mode = 1'b0;
         end
      end else if (SCLO === 1'b1) begin
         rise_log.push_back(cyc);
         if (bitc < 8) sh = {sh[6:0], sda_line};
         else if (rd_mode) begin
            last_mack = sda_line;
            mack_log.push_back({7'd0, sda_line});
         end
         bitc++;
      end else if (SCLO === 1'b0 && scl_p === 1'b1) begin
         if (bitc == 8) begin
            if (rd_mode) s_sda = 1'b1;
            else begin
               wr_log.push_back(sh);
               s_sda = ack_en ? 1'b0 : 1'b1;
            end
         end else if (bitc == 9) begin
            bitc  = 0;
            s_sda = 1'b1;
            if (in_addr) begin
               in_addr = 1'b0;
               if (sh[0] && ack_en) begin
                  rd_mode = 1'b1;
                  cur = tx_data[tx_idx];
                  s_sda = cur[7];
               end
            end else if (rd_mode && !last_mack) begin
               tx_idx++;
               cur = tx_data[tx_idx];
               s_sda = cur[7];
            end
         end else if (rd_mode && bitc >= 1 && bitc <= 7) begin
            cur = tx_data[tx_idx];
            s_sda = cur[7 - bitc];
         end
      end
      scl_p = SCLO;
      sda_p = sda_line;
   end

   always @(negedge CLK) begin
      if (BYTE_VALID) byte_log.push_back(BYTE_DATA);
      if (DONE) done_cnt++;
   end

   function automatic logic [63:0] q8(input logic [7:0] q [$], input int i);
      if (i < q.size()) return {56'd0, q[i]};
      return 64'hDEAD;
   endfunction

   function automatic int qi(input int q [$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   int   b_wr, b_mk, b_by, b_rs, b_st, b_sp;
   logic done_busy, done_err, timed_out;

   task automatic mark();
      b_wr = wr_log.size();
      b_mk = mack_log.size();
      b_by = byte_log.size();
      b_rs = rise_log.size();
      b_st = starts;
      b_sp = stops;
   endtask

   task automatic run_txn(input logic [6:0] a, input logic re,
                          input logic [7:0] ra, input logic [7:0] nb,
                          input logic ack, input logic hold);
      SLAVE_ADDR = a; REG_EN = re; REG_ADDR = ra;
      NUM_BYTES = nb; ack_en = ack;
      mark();
      @(negedge CLK);
      GO = 1'b1;
      if (!hold) begin
         repeat (2) @(negedge CLK);
         GO = 1'b0;
      end
      timed_out = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         if (DONE) begin
            done_busy = BUSY;
            done_err  = ACK_ERR;
            timed_out = 1'b0;
            break;
         end
      end
      chk("done_timeout", {63'd0, timed_out}, 64'd0);
      repeat (2) @(negedge CLK);
   endtask

   int d0;

   initial begin
      #1 RESET_N = 1'b0;
      #20;
      chk("rst_sdao", {63'd0, SDAO}, 64'd1);
      chk("rst_sclo", {63'd0, SCLO}, 64'd1);
      chk("rst_busy", {63'd0, BUSY}, 64'd0);
      chk("rst_done", {63'd0, DONE}, 64'd0);
      chk("rst_ackerr", {63'd0, ACK_ERR}, 64'd0);
      chk("rst_bvalid", {63'd0, BYTE_VALID}, 64'd0);
      chk("rst_data", {32'd0, DATA_OUT}, 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) @(negedge CLK);

      // plain 2-byte read
      tx_data[0] = 8'hAB; tx_data[1] = 8'hCD;
      run_txn(7'h40, 1'b0, 8'h00, 8'd2, 1'b1, 1'b0);
      chk("t1_nwr", wr_log.size() - b_wr, 1);
      chk("t1_addr", q8(wr_log, b_wr), 8'h81);
      chk("t1_nbytes", byte_log.size() - b_by, 2);
      chk("t1_byte0", q8(byte_log, b_by), 8'hAB);
      chk("t1_byte1", q8(byte_log, b_by + 1), 8'hCD);
      chk("t1_mack0", q8(mack_log, b_mk), 8'h00);
      chk("t1_mack1", q8(mack_log, b_mk + 1), 8'h01);
      chk("t1_data", {32'd0, DATA_OUT}, 64'h0000ABCD);
      chk("t1_ackerr", {63'd0, done_err}, 64'd0);
      chk("t1_busy_at_done", {63'd0, done_busy}, 64'd0);
      chk("t1_stop", stops - b_sp, 1);
      chk("t1_scl_period", qi(rise_log, b_rs + 2) - qi(rise_log, b_rs + 1), 16);
      chk("t1_nrise", rise_log.size() - b_rs, 28);

      // register-pointer read with repeated START
      tx_data[0] = 8'h11; tx_data[1] = 8'h22;
      tx_data[2] = 8'h33; tx_data[3] = 8'h44;
      run_txn(7'h1E, 1'b1, 8'h03, 8'd4, 1'b1, 1'b0);
      chk("t2_nwr", wr_log.size() - b_wr, 3);
      chk("t2_wr0", q8(wr_log, b_wr), 8'h3C);
      chk("t2_wr1", q8(wr_log, b_wr + 1), 8'h03);
      chk("t2_wr2", q8(wr_log, b_wr + 2), 8'h3D);
      chk("t2_starts", starts - b_st, 2);
      chk("t2_nbytes", byte_log.size() - b_by, 4);
      chk("t2_mack2", q8(mack_log, b_mk + 2), 8'h00);
      chk("t2_mack3", q8(mack_log, b_mk + 3), 8'h01);
      chk("t2_data", {32'd0, DATA_OUT}, 64'h11223344);

      // address NACK
      run_txn(7'h50, 1'b0, 8'h00, 8'd2, 1'b0, 1'b0);
      chk("t3_ackerr_at_done", {63'd0, done_err}, 64'd1);
      chk("t3_ackerr_held", {63'd0, ACK_ERR}, 64'd1);
      chk("t3_addr", q8(wr_log, b_wr), 8'hA1);
      chk("t3_nbytes", byte_log.size() - b_by, 0);
      chk("t3_stop", stops - b_sp, 1);
      chk("t3_data", {32'd0, DATA_OUT}, 64'd0);

      // NUM_BYTES=0 reads one byte and NACKs it
      tx_data[0] = 8'h5A;
      run_txn(7'h40, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
      chk("t4_ackerr_cleared", {63'd0, done_err}, 64'd0);
      chk("t4_nbytes", byte_log.size() - b_by, 1);
      chk("t4_nmack", mack_log.size() - b_mk, 1);
      chk("t4_mack0", q8(mack_log, b_mk), 8'h01);
      chk("t4_data", {32'd0, DATA_OUT}, 64'h0000005A);

      // NUM_BYTES=9 clamps to 4
      tx_data[0] = 8'h01; tx_data[1] = 8'h02;
      tx_data[2] = 8'h03; tx_data[3] = 8'h04;
      tx_data[4] = 8'h05;
      run_txn(7'h40, 1'b0, 8'h00, 8'd9, 1'b1, 1'b0);
      chk("t5_nbytes", byte_log.size() - b_by, 4);
      chk("t5_mack3", q8(mack_log, b_mk + 3), 8'h01);
      chk("t5_data", {32'd0, DATA_OUT}, 64'h01020304);

      // GO held high does not retrigger
      tx_data[0] = 8'h77;
      d0 = done_cnt;
      run_txn(7'h40, 1'b0, 8'h00, 8'd1, 1'b1, 1'b1);
      repeat (300) @(negedge CLK);
      chk("t6_one_done", done_cnt - d0, 1);
      chk("t6_idle", {63'd0, BUSY}, 64'd0);
      chk("t6_data", {32'd0, DATA_OUT}, 64'h00000077);
      GO = 1'b0;
      repeat (2) @(negedge CLK);

      // reset in the middle of the second read byte
      tx_data[0] = 8'h99; tx_data[1] = 8'h77;
      tx_data[2] = 8'h55; tx_data[3] = 8'h33;
      SLAVE_ADDR = 7'h40; REG_EN = 1'b0; NUM_BYTES = 8'd4; ack_en = 1'b1;
      mark();
      @(negedge CLK);
      GO = 1'b1;
      repeat (2) @(negedge CLK);
      GO = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         if (byte_log.size() - b_by >= 1 && bitc == 4 && SCLO === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      chk("t7_timeout", {63'd0, timed_out}, 64'd0);
      chk("t7_pre_data", {32'd0, DATA_OUT}, 64'h00000099);
      #2 RESET_N = 1'b0;
      #1;
      chk("t7_sdao", {63'd0, SDAO}, 64'd1);
      chk("t7_sclo", {63'd0, SCLO}, 64'd1);
      chk("t7_busy", {63'd0, BUSY}, 64'd0);
      chk("t7_bdata", {56'd0, BYTE_DATA}, 64'd0);
      chk("t7_bvalid", {63'd0, BYTE_VALID}, 64'd0);
      chk("t7_done", {63'd0, DONE}, 64'd0);
      chk("t7_data", {32'd0, DATA_OUT}, 64'd0);
      slv_kick = ~slv_kick;
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK);

      // recovery after reset
      tx_data[0] = 8'hC3; tx_data[1] = 8'h3C;
      run_txn(7'h40, 1'b0, 8'h00, 8'd2, 1'b1, 1'b0);
      chk("t8_nbytes", byte_log.size() - b_by, 2);
      chk("t8_data", {32'd0, DATA_OUT}, 64'h0000C33C);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
